hazard_control_unit: RTL and testbench

- Parametrised successor to the pipeline hazard detection logic for the 5-stage RV32I core; sits between the ID and EX stages and drives PC, IF/ID and ID/EX control.
- Adds to plain load-use detection:
  - multi-cycle load-use stalls for slow data memory;
  - x0 exclusion and per-source use qualifiers;
  - taken-branch flush with a configurable penalty;
  - memory-busy freeze;
  - saturating stall and flush event counters for performance tracking.

---
 rtl/hazard_control_unit.sv | 156 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Hazard control for the 5-stage RV32I pipeline, placed between ID and EX.
// It stalls on load-use hazards (multi-cycle for slow data memory), flushes
// on taken branches with a configurable penalty, and freezes everything while
// data memory is busy. It also keeps saturating stall/flush event counters.
module hazard_control_unit #(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_LAT       = 1,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 16
) (
  input  logic                  ip_clk,
  input  logic                  ip_rst_n,
  input  logic [REG_ADDR_W-1:0] ip_IF_ID_RegisterRS1,
  input  logic [REG_ADDR_W-1:0] ip_IF_ID_RegisterRS2,
  input  logic                  ip_IF_ID_UseRS1,
  input  logic                  ip_IF_ID_UseRS2,
  input  logic [REG_ADDR_W-1:0] ip_ID_EX_RegisterRD,
  input  logic                  ip_ID_EX_MemRead,
  input  logic                  ip_Branch_Taken,
  input  logic                  ip_Mem_Busy,
  output logic                  op_PCWrite,
  output logic                  op_IF_ID_Write,
  output logic                  op_ID_EX_Bubble,
  output logic                  op_IF_ID_Flush,
  output logic                  op_ID_EX_Flush,
  output logic                  op_Pipe_Hold,
  output logic [CNT_W-1:0]      op_Stall_Count,
  output logic [CNT_W-1:0]      op_Flush_Count
);

  // The down-counter must hold the longer of the two remaining-cycle loads.
  localparam int MAX_CYC = (LOAD_LAT > BRANCH_PENALTY) ? LOAD_LAT : BRANCH_PENALTY;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;
  logic             stall_inc;
  logic             flush_inc;

  // Load-use hazard: EX holds a load whose non-x0 destination feeds a used ID source.
  always_comb begin
    hz = ip_ID_EX_MemRead && (ip_ID_EX_RegisterRD != '0) &&
         ((ip_IF_ID_UseRS1 && (ip_ID_EX_RegisterRD == ip_IF_ID_RegisterRS1)) ||
          (ip_IF_ID_UseRS2 && (ip_ID_EX_RegisterRD == ip_IF_ID_RegisterRS2)));
  end

  // Next-state and control outputs; memory busy beats branch beats load stall.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    op_PCWrite      = 1'b1;
    op_IF_ID_Write  = 1'b1;
    op_ID_EX_Bubble = 1'b0;
    op_IF_ID_Flush  = 1'b0;
    op_ID_EX_Flush  = 1'b0;
    op_Pipe_Hold    = 1'b0;

    if (ip_Mem_Busy) begin
      // Full freeze: nothing moves, all state holds.
      op_Pipe_Hold   = 1'b1;
      op_PCWrite     = 1'b0;
      op_IF_ID_Write = 1'b0;
    end else if (ip_Branch_Taken) begin
      // A taken branch always wins over any stall or flush in progress.
      op_IF_ID_Flush = 1'b1;
      op_ID_EX_Flush = 1'b1;
      flush_inc      = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        state_d = FLUSH;
        cnt_d   = CW'(BRANCH_PENALTY - 1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (hz) begin
            op_PCWrite      = 1'b0;
            op_IF_ID_Write  = 1'b0;
            op_ID_EX_Bubble = 1'b1;
            stall_inc       = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = CW'(LOAD_LAT - 1);
            end
          end
        end
        LOAD_STALL: begin
          // The load has already left EX, so hz is no longer visible; hold the stall.
          op_PCWrite      = 1'b0;
          op_IF_ID_Write  = 1'b0;
          op_ID_EX_Bubble = 1'b1;
          stall_inc       = 1'b1;
          cnt_d           = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
          end
        end
        FLUSH: begin
          op_IF_ID_Flush = 1'b1;
          cnt_d          = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating performance counters; they never wrap back to zero.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State, down-counter and counter registers; reset aborts any operation at once.
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign op_Stall_Count = stall_cnt_q;
  assign op_Flush_Count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. Three instances share the stimulus:
// u_a (LOAD_LAT=1, BRANCH_PENALTY=1), u_b (LOAD_LAT=3, BRANCH_PENALTY=2) and
// u_c (LOAD_LAT=1, CNT_W=2). Control outputs are packed as
// {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, Pipe_Hold}.
module tb_hazard_control_unit;

  localparam logic [5:0] C_IDLE  = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b001000;
  localparam logic [5:0] C_BR    = 6'b110110;
  localparam logic [5:0] C_FLUSH = 6'b110100;
  localparam logic [5:0] C_HOLD  = 6'b000001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       use1, use2, mem_read, br, busy;

  logic [5:0]  ctl_a, ctl_b, ctl_c;
  logic [15:0] stall_a, flush_a, stall_b, flush_b;
  logic [1:0]  stall_c, flush_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .BRANCH_PENALTY(1), .CNT_W(16)) u_a (
    .ip_clk(clk), .ip_rst_n(rst_n),
    .ip_IF_ID_RegisterRS1(rs1), .ip_IF_ID_RegisterRS2(rs2),
    .ip_IF_ID_UseRS1(use1), .ip_IF_ID_UseRS2(use2),
    .ip_ID_EX_RegisterRD(rd), .ip_ID_EX_MemRead(mem_read),
    .ip_Branch_Taken(br), .ip_Mem_Busy(busy),
    .op_PCWrite(ctl_a[5]), .op_IF_ID_Write(ctl_a[4]), .op_ID_EX_Bubble(ctl_a[3]),
    .op_IF_ID_Flush(ctl_a[2]), .op_ID_EX_Flush(ctl_a[1]), .op_Pipe_Hold(ctl_a[0]),
    .op_Stall_Count(stall_a), .op_Flush_Count(flush_a)
  );

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .BRANCH_PENALTY(2), .CNT_W(16)) u_b (
    .ip_clk(clk), .ip_rst_n(rst_n),
    .ip_IF_ID_RegisterRS1(rs1), .ip_IF_ID_RegisterRS2(rs2),
    .ip_IF_ID_UseRS1(use1), .ip_IF_ID_UseRS2(use2),
    .ip_ID_EX_RegisterRD(rd), .ip_ID_EX_MemRead(mem_read),
    .ip_Branch_Taken(br), .ip_Mem_Busy(busy),
    .op_PCWrite(ctl_b[5]), .op_IF_ID_Write(ctl_b[4]), .op_ID_EX_Bubble(ctl_b[3]),
    .op_IF_ID_Flush(ctl_b[2]), .op_ID_EX_Flush(ctl_b[1]), .op_Pipe_Hold(ctl_b[0]),
    .op_Stall_Count(stall_b), .op_Flush_Count(flush_b)
  );

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .BRANCH_PENALTY(1), .CNT_W(2)) u_c (
    .ip_clk(clk), .ip_rst_n(rst_n),
    .ip_IF_ID_RegisterRS1(rs1), .ip_IF_ID_RegisterRS2(rs2),
    .ip_IF_ID_UseRS1(use1), .ip_IF_ID_UseRS2(use2),
    .ip_ID_EX_RegisterRD(rd), .ip_ID_EX_MemRead(mem_read),
    .ip_Branch_Taken(br), .ip_Mem_Busy(busy),
    .op_PCWrite(ctl_c[5]), .op_IF_ID_Write(ctl_c[4]), .op_ID_EX_Bubble(ctl_c[3]),
    .op_IF_ID_Flush(ctl_c[2]), .op_ID_EX_Flush(ctl_c[1]), .op_Pipe_Hold(ctl_c[0]),
    .op_Stall_Count(stall_c), .op_Flush_Count(flush_c)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling (well before the falling edge).
  task automatic settle();
    #3;
  endtask

  task automatic load_use(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                          input logic u1, input logic u2);
    mem_read = 1'b1;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    use1     = u1;
    use2     = u2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0;
    use1 = 1'b0; use2 = 1'b0; mem_read = 1'b0; br = 1'b0; busy = 1'b0;

    // Reset values
    #3;
    check_value("rst_ctl", 32'(ctl_a), 32'(C_IDLE));
    check_value("rst_stall", 32'(stall_a), 0);
    check_value("rst_flush", 32'(flush_a), 0);
    cyc();
    rst_n = 1'b1;

    // Single-cycle load-use (u_a)
    load_use(5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
    settle();
    check_value("lu1_c0", 32'(ctl_a), 32'(C_STALL));
    cyc();
    mem_read = 1'b0;
    settle();
    check_value("lu1_c1", 32'(ctl_a), 32'(C_IDLE));
    check_value("lu1_cnt", 32'(stall_a), 1);
    load_use(5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    settle();
    check_value("lu1_x0", 32'(ctl_a), 32'(C_IDLE));
    cyc();
    mem_read = 1'b0;
    settle();
    check_value("lu1_x0_cnt", 32'(stall_a), 1);

    // Multi-cycle load-use (u_b, LOAD_LAT=3)
    do_reset();
    load_use(5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
    settle();
    check_value("lu3_c0", 32'(ctl_b), 32'(C_STALL));
    cyc();
    mem_read = 1'b0;
    settle();
    check_value("lu3_c1", 32'(ctl_b), 32'(C_STALL));
    cyc();
    settle();
    check_value("lu3_c2", 32'(ctl_b), 32'(C_STALL));
    cyc();
    settle();
    check_value("lu3_c3", 32'(ctl_b), 32'(C_IDLE));
    check_value("lu3_cnt", 32'(stall_b), 3);
    load_use(5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
    settle();
    check_value("lu3_nouse", 32'(ctl_b), 32'(C_IDLE));
    cyc();
    mem_read = 1'b0;
    settle();
    check_value("lu3_nouse_cnt", 32'(stall_b), 3);

    // Branch with penalty 2 (u_b)
    do_reset();
    br = 1'b1;
    settle();
    check_value("br_c0", 32'(ctl_b), 32'(C_BR));
    cyc();
    br = 1'b0;
    settle();
    check_value("br_c1", 32'(ctl_b), 32'(C_FLUSH));
    check_value("br_fcnt", 32'(flush_b), 1);
    cyc();
    settle();
    check_value("br_c2", 32'(ctl_b), 32'(C_IDLE));

    // Branch arrives after two stall cycles of a 3-cycle load stall (u_b)
    do_reset();
    load_use(5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
    settle();
    check_value("ab_c0", 32'(ctl_b), 32'(C_STALL));
    cyc();
    mem_read = 1'b0;
    settle();
    check_value("ab_c1", 32'(ctl_b), 32'(C_STALL));
    cyc();
    br = 1'b1;
    settle();
    check_value("ab_c2", 32'(ctl_b), 32'(C_BR));
    cyc();
    br = 1'b0;
    settle();
    check_value("ab_c3", 32'(ctl_b), 32'(C_FLUSH));
    check_value("ab_scnt", 32'(stall_b), 2);
    check_value("ab_fcnt", 32'(flush_b), 1);
    cyc();
    settle();
    check_value("ab_c4", 32'(ctl_b), 32'(C_IDLE));

    // Memory freeze in the middle of a 3-cycle load stall (u_b)
    do_reset();
    load_use(5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
    settle();
    check_value("mb_c0", 32'(ctl_b), 32'(C_STALL));
    cyc();
    mem_read = 1'b0;
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_value($sformatf("mb_hold%0d", i), 32'(ctl_b), 32'(C_HOLD));
      cyc();
    end
    busy = 1'b0;
    settle();
    check_value("mb_cnt_frozen", 32'(stall_b), 1);
    check_value("mb_r1", 32'(ctl_b), 32'(C_STALL));
    cyc();
    settle();
    check_value("mb_r2", 32'(ctl_b), 32'(C_STALL));
    cyc();
    settle();
    check_value("mb_end", 32'(ctl_b), 32'(C_IDLE));
    check_value("mb_cnt", 32'(stall_b), 3);

    // Asynchronous reset during a load stall (u_b)
    do_reset();
    load_use(5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
    settle();
    cyc();
    mem_read = 1'b0;
    settle();
    check_value("ar_pre", 32'(ctl_b), 32'(C_STALL));
    rst_n = 1'b0;
    #1;
    check_value("ar_ctl", 32'(ctl_b), 32'(C_IDLE));
    check_value("ar_scnt", 32'(stall_b), 0);
    check_value("ar_fcnt", 32'(flush_b), 0);
    cyc();
    rst_n = 1'b1;
    settle();
    check_value("ar_after", 32'(ctl_b), 32'(C_IDLE));

    // Saturation with a 2-bit counter (u_c)
    do_reset();
    for (int i = 0; i < 5; i++) begin
      load_use(5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
      settle();
      cyc();
      mem_read = 1'b0;
      settle();
      check_value($sformatf("sat_%0d", i), 32'(stall_c), (i < 3) ? (i + 1) : 3);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
